pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage 16-bit pipeline (IF, ID, EX, MEM, WB). It shadows the destination registers in flight, stalls ID on read-after-write hazards (the datapath has no forwarding), and freezes the pipe while a RAM access completes. It also squashes wrong-path instructions after a PC redirect. Its enables and flushes drive the PC register and the FetchDecode, DecodeExecute and ExecuteMemory pipeline registers.

## Interface
- `REG_ADDR_W`, default 4: register-file address width.
- `MEM_LAT`, default 2: RAM access latency in cycles, legal range 1..7. A memory op occupies MEM for `MEM_LAT` cycles.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: reset, synchronous and active-low (0 = reset, sampled on `clk`).
- `id_valid` input 1: ID holds a real instruction.
- `id_src_a`, `id_src_b`, `id_src_c` input `REG_ADDR_W` each: regfile read addresses a1, a2, a3.
- `id_src_used` input 3: bit i = source i is actually read (a, b, c).
- `id_wre` input 1: ID instruction writes the regfile.
- `id_dst` input `REG_ADDR_W`: ID destination register.
- `id_is_mem` input 1: ID instruction accesses RAM (load or store).
- `ex_redirect` input 1: instruction in EX changes the PC.
- `pc_en` output 1: PC register load enable.
- `fd_en` output 1: FetchDecode register enable.
- `fd_flush` output 1: clear FetchDecode to a bubble.
- `de_bubble` output 1: load a bubble (all control bits 0) into DecodeExecute.
- `pipe_en` output 1: enable for DecodeExecute, ExecuteMemory and MemoryWriteback.
- `mem_busy` output 1: state is MEM_WAIT.
- `stall_cycles` output 16: saturating count of cycles with `pc_en`=0.

## Operation
- Shadow slots EX, MEM and WB each hold {valid, wre, dst, is_mem}.
- Advance rule: when `pipe_en`=1, WB takes MEM, MEM takes EX, and EX takes the ID info. EX takes a bubble instead if `de_bubble`=1.
- raw: `id_valid` and any used source equals the dst of a valid, wre slot in EX, MEM or WB.
  - WB counts as a hazard because the regfile write lands at the edge ending WB.
  - A source equal to dst 0 still counts.
- States: RUN, FLUSH, MEM_WAIT. There is also a `flush_pend` bit and a 3-bit `mem_cnt`.
- RUN / FLUSH (pipe advancing, `pipe_en`=1):
  - redirect accepted when `ex_redirect`=1: `fd_flush`=1, `de_bubble`=1, `pc_en`=1. Next state is FLUSH.
  - else raw, or state FLUSH: `pc_en`=0, `fd_en`=0, `de_bubble`=1.
    - In FLUSH the instruction in ID is the stale ROM output, so `fd_flush`=1 as well.
    - FLUSH always returns to RUN after 1 cycle.
  - else: all enables are 1.
- Memory stall: if the EX slot is valid, is_mem, `pipe_en`=1 and `MEM_LAT`>1:
  - next state is MEM_WAIT, with `mem_cnt` loaded to `MEM_LAT`-1.
  - If a redirect is accepted in the same cycle, `flush_pend` is set to 1 and MEM_WAIT takes precedence.
- MEM_WAIT:
  - `pc_en`=`fd_en`=`pipe_en`=0, `de_bubble`=0, `fd_flush`=0. `ex_redirect` is ignored.
  - `mem_cnt` decrements each cycle. When `mem_cnt`=1, the next state is FLUSH if `flush_pend`=1 (clearing it), otherwise RUN.
- Priority: reset > MEM_WAIT freeze > redirect > raw.
- `stall_cycles`: +1 on each cycle with `pc_en`=0 and `reset`=1. Saturates at 16'hFFFF (no wrap).

## Timing
- While `reset`=0, at the edge: state=RUN, all slots invalid, `flush_pend`=0, `mem_cnt`=0, `stall_cycles`=0.
- Outputs while `reset`=0: `pc_en`=0, `fd_en`=0, `fd_flush`=1, `de_bubble`=1, `pipe_en`=0, `mem_busy`=0.
- Reset asserted mid-MEM_WAIT or mid-FLUSH abandons the operation at that edge.
- Outputs are combinational from state, slots and ID inputs, with no added latency. State and slots are registered.
- RAW with producer in EX: the consumer stalls 3 cycles and issues on the 4th. Producer in MEM: 2 cycles. Producer in WB: 1 cycle.
- A redirect costs exactly 2 bubbles: the ID instruction plus the ROM instruction in flight.
- A memory op adds `MEM_LAT`-1 frozen cycles.

## Structure
- Package `pipe_ctrl_pkg`:
  - `ctrl_state_t` enum {RUN, FLUSH, MEM_WAIT}
  - `slot_t` packed struct
  - `REG_ADDR_W` default
  - `BUBBLE_SLOT` constant
- Sub-module `hazard_match`: combinational. Compares the 3 sources against the 3 slots and returns raw. It is instantiated once.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then release → `pc_en`=0 and `fd_flush`=1 during reset. `stall_cycles`=0 and `pc_en`=1 on the first cycle after release.
- RAW from EX: cycle 0 issues wre dst=3; cycle 1 has ID with `id_src_a`=3 used → `pc_en`=0 and `de_bubble`=1 for exactly 3 cycles, then issue. `stall_cycles`=3.
- Unused source: same as above but `id_src_used`=3'b000 → no stall.
- Redirect: `ex_redirect`=1 for 1 cycle → `fd_flush`=1 on 2 consecutive cycles and `de_bubble`=1 on 2 cycles, then RUN.
- Memory latency: `MEM_LAT`=4, load issues → `mem_busy`=1 for 3 cycles with `pipe_en`=0. A redirect in the entry cycle produces FLUSH immediately after MEM_WAIT.
- Saturation: force 70000 stall cycles via a persistent dependency → `stall_cycles` holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: controller states and the
// per-stage shadow record of an instruction in flight.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W_DFLT = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic                       valid;
    logic                       wre;
    logic [REG_ADDR_W_DFLT-1:0] dst;
    logic                       is_mem;
  } slot_t;

  localparam slot_t BUBBLE_SLOT = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// Read-after-write detector: any used ID source matching a pending write in EX, MEM or WB.
// WB still counts because the regfile write only lands at the edge that ends WB.
module hazard_match
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DFLT
) (
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src_a,
  input  logic [REG_ADDR_W-1:0] id_src_b,
  input  logic [REG_ADDR_W-1:0] id_src_c,
  input  logic [2:0]            id_src_used,
  input  slot_t                 slot_ex,
  input  slot_t                 slot_mem,
  input  slot_t                 slot_wb,
  output logic                  raw
);

  logic [REG_ADDR_W-1:0] src [3];
  slot_t                 slots [3];
  logic                  unused_is_mem;

  assign src[0]   = id_src_a;
  assign src[1]   = id_src_b;
  assign src[2]   = id_src_c;
  assign slots[0] = slot_ex;
  assign slots[1] = slot_mem;
  assign slots[2] = slot_wb;
  assign unused_is_mem = slot_ex.is_mem ^ slot_mem.is_mem ^ slot_wb.is_mem;

  always_comb begin
    raw = 1'b0;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 3; k++) begin
        if (id_src_used[s] && slots[k].valid && slots[k].wre && (slots[k].dst == src[s]))
          raw = 1'b1;
      end
    end
    raw = raw & id_valid;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: RAW stalls (no forwarding), RAM-access
// freezes and wrong-path squash after a PC redirect.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DFLT,
  parameter int MEM_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src_a,
  input  logic [REG_ADDR_W-1:0] id_src_b,
  input  logic [REG_ADDR_W-1:0] id_src_c,
  input  logic [2:0]            id_src_used,
  input  logic                  id_wre,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_is_mem,
  input  logic                  ex_redirect,
  output logic                  pc_en,
  output logic                  fd_en,
  output logic                  fd_flush,
  output logic                  de_bubble,
  output logic                  pipe_en,
  output logic                  mem_busy,
  output logic [15:0]           stall_cycles
);

  localparam logic [2:0] MEM_CNT_INIT = 3'(MEM_LAT - 1);
  localparam bit         MEM_STALL_EN = (MEM_LAT > 1);

  ctrl_state_t state_q, state_d;
  logic        flush_pend_q, flush_pend_d;
  logic [2:0]  mem_cnt_q, mem_cnt_d;
  slot_t       ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [15:0] stall_q, stall_d;
  logic        raw;

  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_match (
    .id_valid    (id_valid),
    .id_src_a    (id_src_a),
    .id_src_b    (id_src_b),
    .id_src_c    (id_src_c),
    .id_src_used (id_src_used),
    .slot_ex     (ex_q),
    .slot_mem    (mem_q),
    .slot_wb     (wb_q),
    .raw         (raw)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      mem_cnt_q    <= '0;
      ex_q         <= BUBBLE_SLOT;
      mem_q        <= BUBBLE_SLOT;
      wb_q         <= BUBBLE_SLOT;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      mem_cnt_q    <= mem_cnt_d;
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      stall_q      <= stall_d;
    end
  end

  // Next state: a memory op leaving EX overrides a same-cycle redirect, which is parked in flush_pend.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    mem_cnt_d    = mem_cnt_q;
    if (state_q == MEM_WAIT) begin
      mem_cnt_d = mem_cnt_q - 3'd1;
      if (mem_cnt_q == 3'd1) begin
        state_d      = flush_pend_q ? FLUSH : RUN;
        flush_pend_d = 1'b0;
      end
    end else begin
      state_d = ex_redirect ? FLUSH : RUN;
      if (MEM_STALL_EN && ex_q.valid && ex_q.is_mem) begin
        state_d   = MEM_WAIT;
        mem_cnt_d = MEM_CNT_INIT;
        if (ex_redirect) flush_pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    pc_en     = 1'b0;
    fd_en     = 1'b0;
    fd_flush  = 1'b1;
    de_bubble = 1'b1;
    pipe_en   = 1'b0;
    mem_busy  = 1'b0;
    if (reset) begin
      if (state_q == MEM_WAIT) begin
        fd_flush  = 1'b0;
        de_bubble = 1'b0;
        mem_busy  = 1'b1;
      end else begin
        pipe_en = 1'b1;
        if (ex_redirect) begin
          pc_en = 1'b1;
          fd_en = 1'b1;
        end else if (raw || state_q == FLUSH) begin
          fd_flush = (state_q == FLUSH);
        end else begin
          pc_en     = 1'b1;
          fd_en     = 1'b1;
          fd_flush  = 1'b0;
          de_bubble = 1'b0;
        end
      end
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (pipe_en) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (de_bubble) ex_d = BUBBLE_SLOT;
      else           ex_d = '{valid: id_valid, wre: id_wre, dst: id_dst, is_mem: id_is_mem};
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  assign stall_cycles = stall_q;

endmodule
